// File: rtl/mem_uncache_ctrl.sv
// Uncached load/store controller between the MEM1 stage and the AXI bridge.
// One request at a time: latch it in IDLE, run the read or write handshake, pulse DONE.
module mem_uncache_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM1_uncache_valid,
    input  logic              MEM1_DMWr,
    input  logic [ADDR_W-1:0] MEM1_Paddr,
    input  logic [3:0]        MEM1_dCache_wstrb,
    input  logic [31:0]       MEM1_wdata,
    input  logic [1:0]        MEM1_rsize,
    output logic              MEM_unCache_data_ok,
    output logic [31:0]       uncache_Out,
    output logic              MEM_uncache_rd_req,
    output logic [2:0]        rd_type,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    input  logic [31:0]       ret_data,
    output logic              MEM_uncache_wr_req,
    output logic [2:0]        wr_type,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_wstrb,
    output logic [31:0]       wr_data,
    input  logic              wr_rdy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_wdata;
    logic              r_dmwr;
    logic [1:0]        r_rsize;
    logic [31:0]       r_rdata;

    // Request fields are captured only on acceptance in IDLE, so they stay frozen for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_dmwr  <= 1'b0;
            r_rsize <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (MEM1_uncache_valid) begin
                        r_addr  <= MEM1_Paddr;
                        r_wstrb <= MEM1_dCache_wstrb;
                        r_wdata <= MEM1_wdata;
                        r_dmwr  <= MEM1_DMWr;
                        r_rsize <= MEM1_rsize;
                        r_state <= MEM1_DMWr ? WR_REQ : RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (rd_rdy) r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (ret_valid && ret_last) begin
                        r_rdata <= ret_data;
                        r_state <= DONE;
                    end
                end
                WR_REQ: begin
                    if (wr_rdy) r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MEM_uncache_rd_req  = (r_state == RD_REQ) && !r_dmwr;
    assign MEM_uncache_wr_req  = (r_state == WR_REQ) && r_dmwr;
    assign rd_type             = {1'b0, r_rsize};
    assign rd_addr             = r_addr;
    // Writes always go out as a full aligned word; the strobes pick the bytes.
    assign wr_type             = 3'b010;
    assign wr_addr             = {r_addr[ADDR_W-1:2], 2'b00};
    assign wr_wstrb            = r_wstrb;
    assign wr_data             = r_wdata;
    assign uncache_Out         = r_rdata;
    assign MEM_unCache_data_ok = ((r_state == IDLE) && !MEM1_uncache_valid) || (r_state == DONE);

endmodule

// File: doc/mem_uncache_ctrl.md
MEM_UNCACHE_CTRL -- requirements
Module: mem_uncache_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, physical address width; all address ports are ADDR_W bits.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 MEM1_uncache_valid  in  1  uncached load/store request from MEM1 (already exception/eret-qualified).
REQ-005 MEM1_DMWr  in  1  1 = store, 0 = load.
REQ-006 MEM1_Paddr  in  ADDR_W  physical byte address.
REQ-007 MEM1_dCache_wstrb  in  4  store byte enables.
REQ-008 MEM1_wdata  in  32  lane-aligned store data.
REQ-009 MEM1_rsize  in  2  load size: 00 byte, 01 half, 10 word.
REQ-010 MEM_unCache_data_ok  out  1  high when no transaction is outstanding or one completes this cycle.
REQ-011 uncache_Out  out  32  raw bus word returned by the last load.
REQ-012 MEM_uncache_rd_req / rd_type[2:0] / rd_addr[ADDR_W]  out  read request channel.
REQ-013 rd_rdy  in  1  bridge accepts the read request.
REQ-014 ret_valid / ret_last  in  1 each; ret_data  in  32  read return.
REQ-015 MEM_uncache_wr_req / wr_type[2:0] / wr_addr[ADDR_W] / wr_wstrb[4] / wr_data[32]  out  write request channel.
REQ-016 wr_rdy  in  1  bridge accepts the write; the write is complete from this block's view.

Function
REQ-017 The FSM SHALL have states IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE, encoded in a registered state variable.
REQ-018 IDLE: MEM1_uncache_valid=1 latches addr, wstrb, wdata, DMWr and rsize; next state is WR_REQ if DMWr=1, else RD_REQ. The request is accepted only in IDLE.
REQ-019 RD_REQ: rd_req=1 and rd_addr/rd_type are driven from the latches; rd_req&rd_rdy moves to RD_WAIT; otherwise the state holds and all outputs stay stable.
REQ-020 rd_type SHALL be {1'b0, rsize}; rd_addr SHALL be the latched address unmodified.
REQ-021 RD_WAIT: ret_valid&ret_last captures ret_data into uncache_Out and moves to DONE; ret_valid without ret_last is ignored.
REQ-022 ret_valid seen in IDLE, RD_REQ, WR_REQ or DONE SHALL be ignored and SHALL leave uncache_Out unchanged.
REQ-023 WR_REQ: wr_req=1, wr_type=3'b010, wr_addr={addr[ADDR_W-1:2],2'b00}, with latched wstrb and wdata; wr_req&wr_rdy moves to DONE.
REQ-024 DONE lasts exactly one cycle and then returns to IDLE; MEM1_uncache_valid in DONE is not accepted.
REQ-025 MEM_unCache_data_ok SHALL be combinational: (state==IDLE && !MEM1_uncache_valid) || state==DONE.
REQ-026 rd_req and wr_req SHALL be registered-state decodes, never high together, and held until their handshake completes.
REQ-027 uncache_Out SHALL hold its value until the next completed load; stores do not alter it.
REQ-028 Minimum latency: load accepted at cycle T completes with data_ok=1 at T+3 (rdy at T+1, ret at T+2); store accepted at T completes at T+2.
REQ-029 Address and strobe latches SHALL NOT change while state != IDLE, whatever MEM1 inputs do.

Reset
REQ-030 On a rst=1 clock edge: state=IDLE, uncache_Out=0, latches=0; rd_req=wr_req=0 in the following cycle.
REQ-031 rst mid-transaction SHALL abandon it. No DONE is produced, and a later ret_valid for the abandoned read is ignored per REQ-022.
REQ-032 With rst held high, MEM_unCache_data_ok SHALL follow REQ-025 for IDLE; requests presented during reset are not latched.

Verification
REQ-033 Load word at 0x1FAF_F020, rd_rdy=1, ret at next cycle with data 0xDEAD_BEEF -> rd_type=010, rd_addr=0x1FAF_F020, data_ok at T+3, uncache_Out=0xDEAD_BEEF.
REQ-034 Store at 0x1FAF_F013, wstrb=1000, wdata=0xAB00_0000, wr_rdy low for 3 cycles -> wr_req held 4 cycles, wr_addr=0x1FAF_F010, wr_type=010, data_ok high only in DONE.
REQ-035 Load byte at 0x1FAF_F001 with a stray ret_valid during RD_REQ -> stray data ignored, rd_type=000, and only the RD_WAIT return updates uncache_Out.
REQ-036 rst asserted in RD_WAIT, then ret_valid&ret_last -> no DONE, uncache_Out=0, state IDLE.
REQ-037 Back-to-back store then load with valid held continuously -> second request accepted in the IDLE cycle after DONE, never in DONE.
REQ-038 Randomized rdy/ret delays (0-8 cycles) -> rd_req and wr_req never both high, no lost or duplicated completion.
